// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and constants for the two-requester APB arbiter in front of
// the blockA/blockB register decode fabric.
package apb_req_arbiter_pkg;

  localparam int APB_ADDR_W      = 32;
  localparam int APB_DATA_W      = 32;
  localparam int APB_ARB_TIMEOUT = 16;

  typedef logic [APB_ADDR_W-1:0] apb_addr_t;
  typedef logic [APB_DATA_W-1:0] apb_data_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_e;

  // Width of the ACCESS wait counter; never narrower than one bit so a
  // disabled timeout (0) still yields a legal vector.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/apb_arb_rr2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// the requester that was not served last.
module apb_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  // Select the winner from the current requests and the previous owner
  always_comb begin
    grant = 1'b0;
    valid = 1'b0;
    case (req)
      2'b01: begin
        grant = 1'b0;
        valid = 1'b1;
      end
      2'b10: begin
        grant = 1'b1;
        valid = 1'b1;
      end
      2'b11: begin
        grant = ~last_grant;
        valid = 1'b1;
      end
      default: begin
        grant = 1'b0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one downstream APB completer between two APB requesters. The
// granted transfer is re-issued downstream with its own SETUP/ACCESS phases,
// the response is routed back to the owner, and a hung ACCESS is cut off
// after TIMEOUT cycles with an error response.
module apb_req_arbiter
  import apb_req_arbiter_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_ARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic [DATA_W-1:0] m0_pwdata,
  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic              m0_pwrite,
  output logic              m0_pready,
  output logic              m0_pslverr,
  output logic [DATA_W-1:0] m0_prdata,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic [DATA_W-1:0] m1_pwdata,
  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic              m1_pwrite,
  output logic              m1_pready,
  output logic              m1_pslverr,
  output logic [DATA_W-1:0] m1_prdata,
  output logic [ADDR_W-1:0] s_paddr,
  output logic [DATA_W-1:0] s_pwdata,
  output logic              s_psel,
  output logic              s_penable,
  output logic              s_pwrite,
  input  logic              s_pready,
  input  logic              s_pslverr,
  input  logic [DATA_W-1:0] s_prdata,
  output logic              grant_id,
  output logic              timeout_evt
);

  localparam int               CNT_W    = cnt_width(TIMEOUT);
  localparam bit               TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_e        state_r;
  arb_state_e        state_next_s;
  logic              last_grant_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              arb_grant_s;
  logic              arb_valid_s;
  logic              tmo_s;
  logic              resp_valid_s;
  logic              resp_slverr_s;
  logic [DATA_W-1:0] resp_rdata_s;
  logic              unused_s;

  // The requester-side enable carries no information the arbiter needs:
  // psel alone marks a pending request.
  assign unused_s = m0_penable ^ m1_penable;

  apb_arb_rr2 u_rr2 (
    .req        ({m1_psel, m0_psel}),
    .last_grant (last_grant_r),
    .grant      (arb_grant_s),
    .valid      (arb_valid_s)
  );

  // Timeout fires on the last allowed ACCESS cycle unless the completer
  // answers in that same cycle.
  assign tmo_s = TMO_EN && (state_r == ST_ACCESS) && !s_pready && (cnt_r == CNT_LAST);

  // Advance the transfer state machine
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Decide the next transfer phase
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (arb_valid_s) begin
          state_next_s = ST_SETUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_next_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (s_pready || tmo_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ACCESS;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Downstream bus registers, ownership, wait counter and timeout pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_paddr      <= '0;
      s_pwdata     <= '0;
      s_psel       <= 1'b0;
      s_penable    <= 1'b0;
      s_pwrite     <= 1'b0;
      grant_id     <= 1'b0;
      last_grant_r <= 1'b1;
      cnt_r        <= '0;
      timeout_evt  <= 1'b0;
    end else begin
      timeout_evt <= tmo_s;
      case (state_r)
        ST_IDLE: begin
          if (arb_valid_s) begin
            if (arb_grant_s) begin
              s_paddr  <= m1_paddr;
              s_pwdata <= m1_pwdata;
              s_pwrite <= m1_pwrite;
            end else begin
              s_paddr  <= m0_paddr;
              s_pwdata <= m0_pwdata;
              s_pwrite <= m0_pwrite;
            end
            s_psel    <= 1'b1;
            s_penable <= 1'b0;
            grant_id  <= arb_grant_s;
          end
        end
        ST_SETUP: begin
          s_penable <= 1'b1;
          cnt_r     <= '0;
        end
        ST_ACCESS: begin
          if (s_pready || tmo_s) begin
            s_psel       <= 1'b0;
            s_penable    <= 1'b0;
            last_grant_r <= grant_id;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          s_psel    <= 1'b0;
          s_penable <= 1'b0;
        end
      endcase
    end
  end

  // Build the response and steer it to the owner only; a requester that
  // has already dropped psel gets nothing back.
  always_comb begin
    resp_valid_s  = 1'b0;
    resp_slverr_s = 1'b0;
    resp_rdata_s  = '0;
    m0_pready     = 1'b0;
    m0_pslverr    = 1'b0;
    m0_prdata     = '0;
    m1_pready     = 1'b0;
    m1_pslverr    = 1'b0;
    m1_prdata     = '0;
    if ((state_r == ST_ACCESS) && s_pready) begin
      resp_valid_s  = 1'b1;
      resp_slverr_s = s_pslverr;
      resp_rdata_s  = s_prdata;
    end else if (tmo_s) begin
      resp_valid_s  = 1'b1;
      resp_slverr_s = 1'b1;
      resp_rdata_s  = '0;
    end else begin
      resp_valid_s  = 1'b0;
      resp_slverr_s = 1'b0;
      resp_rdata_s  = '0;
    end
    if (resp_valid_s && (grant_id == 1'b0) && m0_psel) begin
      m0_pready  = 1'b1;
      m0_pslverr = resp_slverr_s;
      m0_prdata  = resp_rdata_s;
    end else if (resp_valid_s && (grant_id == 1'b1) && m1_psel) begin
      m1_pready  = 1'b1;
      m1_pslverr = resp_slverr_s;
      m1_prdata  = resp_rdata_s;
    end else begin
      m0_pready = 1'b0;
      m1_pready = 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios plus a
// randomized run, checked against a transfer-level model (who wins, when the
// response arrives, what it carries).
module tb_apb_req_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [ADDR_W-1:0] m0_paddr, m1_paddr;
  logic [DATA_W-1:0] m0_pwdata, m1_pwdata;
  logic              m0_psel, m1_psel, m0_pwrite, m1_pwrite;
  wire               m0_penable = m0_psel;
  wire               m1_penable = m1_psel;
  logic              m0_pready, m0_pslverr, m1_pready, m1_pslverr;
  logic [DATA_W-1:0] m0_prdata, m1_prdata;
  logic [ADDR_W-1:0] s_paddr;
  logic [DATA_W-1:0] s_pwdata, s_prdata;
  logic              s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
  logic              grant_id, timeout_evt;

  apb_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_psel(m0_psel), .m0_penable(m0_penable),
    .m0_pwrite(m0_pwrite), .m0_pready(m0_pready), .m0_pslverr(m0_pslverr), .m0_prdata(m0_prdata),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_psel(m1_psel), .m1_penable(m1_penable),
    .m1_pwrite(m1_pwrite), .m1_pready(m1_pready), .m1_pslverr(m1_pslverr), .m1_prdata(m1_prdata),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_psel(s_psel), .s_penable(s_penable),
    .s_pwrite(s_pwrite), .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
    .grant_id(grant_id), .timeout_evt(timeout_evt)
  );

  int vectors     = 0;
  int miscompares = 0;
  int model_last  = 1;   // requester served most recently (reset: 1, so 0 wins a tie)

  // Observations of one transfer, cycle 0 = cycle the request is presented
  int          r_who, r_psel_cyc, r_done_cyc, r_evt_during, r_other_bad, r_unstable;
  logic [31:0] r_rdata, r_paddr, r_pwdata;
  logic        r_err, r_pwrite;

  // Completer model: answers on ACCESS cycle waits+1. Entered at posedge+1 of
  // cycle 0, leaves at posedge+1 of the cycle after the response.
  task automatic serve(input int waits, input logic [31:0] rdata, input logic err, input bit keep);
    int acc;
    logic [31:0] rnd;
    acc = 0;
    r_who = -1; r_psel_cyc = -1; r_done_cyc = -1;
    r_evt_during = 0; r_other_bad = 0; r_unstable = 0;
    r_rdata = 32'h0; r_err = 1'b0;
    for (int c = 0; c < 200; c++) begin
      rnd = $urandom;
      if (s_psel && s_penable) acc++;
      s_pready  = s_psel && s_penable && (acc == waits + 1);
      s_prdata  = s_pready ? rdata : rnd;
      s_pslverr = s_pready ? err : rnd[7];
      @(negedge clk);
      if (c > 0 && timeout_evt) r_evt_during++;
      if (s_psel && r_psel_cyc < 0) begin
        r_psel_cyc = c; r_who = int'(grant_id);
        r_paddr = s_paddr; r_pwdata = s_pwdata; r_pwrite = s_pwrite;
      end else if (s_psel && (s_paddr !== r_paddr || s_pwdata !== r_pwdata || s_pwrite !== r_pwrite)) begin
        r_unstable++;
      end
      if (r_who == 0 && (m1_pready || m1_pslverr || m1_prdata != 32'h0)) r_other_bad++;
      if (r_who == 1 && (m0_pready || m0_pslverr || m0_prdata != 32'h0)) r_other_bad++;
      if ((r_who == 0 && m0_pready) || (r_who == 1 && m1_pready)) begin
        r_done_cyc = c;
        r_rdata = (r_who == 1) ? m1_prdata : m0_prdata;
        r_err   = (r_who == 1) ? m1_pslverr : m0_pslverr;
      end
      @(posedge clk); #1;
      if (r_done_cyc >= 0) begin
        s_pready = 1'b0;
        if (!keep) begin
          if (r_who == 1) m1_psel = 1'b0; else m0_psel = 1'b0;
        end
        break;
      end
    end
    s_pready = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; m0_psel = 1'b0; m1_psel = 1'b0; s_pready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; model_last = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_pready = 1'b0; s_pslverr = 1'b0; s_prdata = 32'h0;
    m0_psel = 1'b1; m0_paddr = 32'h0000_0040; m0_pwdata = 32'h0; m0_pwrite = 1'b1;
    m1_psel = 1'b0; m1_paddr = 32'h0; m1_pwdata = 32'h0; m1_pwrite = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if ({s_psel, s_penable, s_pwrite, grant_id, timeout_evt, m0_pready, m0_pslverr, m1_pready, m1_pslverr} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 000000000",
               {s_psel, s_penable, s_pwrite, grant_id, timeout_evt, m0_pready, m0_pslverr, m1_pready, m1_pslverr});
    end
    vectors++;
    if ({s_paddr, s_pwdata, m0_prdata, m1_prdata} !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h %h %h %h expected all zero", s_paddr, s_pwdata, m0_prdata, m1_prdata);
    end
    rst_n = 1'b1; m0_psel = 1'b0; model_last = 1;
  endtask

  task automatic test_single_read();
    m0_psel = 1'b1; m0_paddr = 32'h0000_1004; m0_pwrite = 1'b0;
    serve(2, 32'hDEAD_BEEF, 1'b0, 1'b0);
    vectors++; if (r_who !== 0) begin miscompares++; $display("FAIL read_who: got %0d expected 0", r_who); end
    vectors++; if (r_psel_cyc !== 1) begin miscompares++; $display("FAIL read_psel_cycle: got %0d expected 1", r_psel_cyc); end
    vectors++; if (r_done_cyc !== 4) begin miscompares++; $display("FAIL read_pready_cycle: got %0d expected 4", r_done_cyc); end
    vectors++; if (r_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL read_prdata: got %h expected deadbeef", r_rdata); end
    vectors++; if (r_paddr !== 32'h0000_1004) begin miscompares++; $display("FAIL read_paddr: got %h expected 00001004", r_paddr); end
    vectors++; if (r_other_bad !== 0) begin miscompares++; $display("FAIL read_m1_quiet: got %0d bad cycles expected 0", r_other_bad); end
    model_last = 0;
  endtask

  task automatic test_contention();
    apply_reset();
    m0_psel = 1'b1; m0_paddr = 32'h0000_1000; m0_pwrite = 1'b0;
    m1_psel = 1'b1; m1_paddr = 32'h0000_2000; m1_pwrite = 1'b0;
    serve(0, 32'h0000_0A00, 1'b0, 1'b0);
    vectors++; if (r_who !== 0) begin miscompares++; $display("FAIL tie1_who: got %0d expected 0", r_who); end
    vectors++; if (r_paddr !== 32'h0000_1000) begin miscompares++; $display("FAIL tie1_paddr: got %h expected 00001000", r_paddr); end
    model_last = 0;
    serve(1, 32'h0000_0B00, 1'b0, 1'b0);
    vectors++; if (r_who !== 1) begin miscompares++; $display("FAIL tie1_second_who: got %0d expected 1", r_who); end
    vectors++; if (r_paddr !== 32'h0000_2000) begin miscompares++; $display("FAIL tie1_second_paddr: got %h expected 00002000", r_paddr); end
    vectors++; if (r_done_cyc !== 3) begin miscompares++; $display("FAIL tie1_second_cycle: got %0d expected 3", r_done_cyc); end
    model_last = 1;
    m0_psel = 1'b1; m1_psel = 1'b1;
    serve(0, 32'h0, 1'b0, 1'b1);
    vectors++; if (r_who !== 0) begin miscompares++; $display("FAIL tie2_who: got %0d expected 0", r_who); end
    model_last = 0;
    serve(0, 32'h0, 1'b0, 1'b0);
    vectors++; if (r_who !== 1) begin miscompares++; $display("FAIL tie3_who: got %0d expected 1", r_who); end
    model_last = 1;
    serve(0, 32'h0, 1'b0, 1'b0);
    vectors++; if (r_who !== 0) begin miscompares++; $display("FAIL tie3_rest_who: got %0d expected 0", r_who); end
    model_last = 0;
  endtask

  task automatic test_write();
    m1_psel = 1'b1; m1_paddr = 32'h0000_2010; m1_pwdata = 32'h1234_5678; m1_pwrite = 1'b1;
    serve(1, 32'h5555_AAAA, 1'b1, 1'b0);
    vectors++; if (r_who !== 1) begin miscompares++; $display("FAIL write_who: got %0d expected 1", r_who); end
    vectors++; if (r_pwrite !== 1'b1) begin miscompares++; $display("FAIL write_pwrite: got %b expected 1", r_pwrite); end
    vectors++; if (r_pwdata !== 32'h1234_5678) begin miscompares++; $display("FAIL write_pwdata: got %h expected 12345678", r_pwdata); end
    vectors++; if (r_unstable !== 0) begin miscompares++; $display("FAIL write_stable: got %0d changes expected 0", r_unstable); end
    vectors++; if (r_err !== 1'b1) begin miscompares++; $display("FAIL write_pslverr: got %b expected 1", r_err); end
    vectors++; if (r_other_bad !== 0) begin miscompares++; $display("FAIL write_m0_quiet: got %0d expected 0", r_other_bad); end
    model_last = 1;
  endtask

  task automatic test_timeout();
    m0_psel = 1'b1; m0_paddr = 32'h0000_1008; m0_pwrite = 1'b0;
    serve(40, 32'h7777_7777, 1'b0, 1'b0);
    vectors++; if (r_done_cyc !== TIMEOUT + 1) begin miscompares++; $display("FAIL tmo_cycle: got %0d expected %0d", r_done_cyc, TIMEOUT + 1); end
    vectors++; if (r_err !== 1'b1) begin miscompares++; $display("FAIL tmo_pslverr: got %b expected 1", r_err); end
    vectors++; if (r_rdata !== 32'h0) begin miscompares++; $display("FAIL tmo_prdata: got %h expected 0", r_rdata); end
    vectors++; if (r_evt_during !== 0) begin miscompares++; $display("FAIL tmo_evt_early: got %0d expected 0", r_evt_during); end
    vectors++; if (timeout_evt !== 1'b1) begin miscompares++; $display("FAIL tmo_evt: got %b expected 1", timeout_evt); end
    vectors++; if (s_psel !== 1'b0) begin miscompares++; $display("FAIL tmo_psel_drop: got %b expected 0", s_psel); end
    @(posedge clk); #1;
    vectors++; if (timeout_evt !== 1'b0) begin miscompares++; $display("FAIL tmo_evt_pulse: got %b expected 0", timeout_evt); end
    model_last = 0;
    m0_psel = 1'b1;
    serve(TIMEOUT - 1, 32'hCAFE_0001, 1'b0, 1'b0);
    vectors++; if (r_done_cyc !== TIMEOUT + 1) begin miscompares++; $display("FAIL tmo_edge_cycle: got %0d expected %0d", r_done_cyc, TIMEOUT + 1); end
    vectors++; if (r_err !== 1'b0) begin miscompares++; $display("FAIL tmo_edge_pslverr: got %b expected 0", r_err); end
    vectors++; if (r_rdata !== 32'hCAFE_0001) begin miscompares++; $display("FAIL tmo_edge_prdata: got %h expected cafe0001", r_rdata); end
    vectors++; if (timeout_evt !== 1'b0) begin miscompares++; $display("FAIL tmo_edge_evt: got %b expected 0", timeout_evt); end
    model_last = 0;
  endtask

  task automatic test_reset_mid();
    m0_psel = 1'b1; m0_paddr = 32'h0000_3000; m0_pwdata = 32'hA5A5_5A5A; m0_pwrite = 1'b1;
    m1_psel = 1'b0; s_pready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    vectors++; if (s_penable !== 1'b1) begin miscompares++; $display("FAIL rmid_in_access: got %b expected 1", s_penable); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({s_psel, s_penable, s_pwrite, grant_id, timeout_evt, m0_pready, m0_pslverr, m1_pready, m1_pslverr} !== 9'b0) begin
      miscompares++;
      $display("FAIL rmid_ctrl: got %b expected 000000000",
               {s_psel, s_penable, s_pwrite, grant_id, timeout_evt, m0_pready, m0_pslverr, m1_pready, m1_pslverr});
    end
    vectors++;
    if ({s_paddr, s_pwdata, m0_prdata} !== 96'h0) begin
      miscompares++; $display("FAIL rmid_data: got %h %h %h expected all zero", s_paddr, s_pwdata, m0_prdata);
    end
    rst_n = 1'b1; model_last = 1;
    m1_psel = 1'b1; m1_paddr = 32'h0000_2000; m1_pwrite = 1'b0;
    serve(1, 32'h0BAD_F00D, 1'b0, 1'b0);
    vectors++; if (r_who !== 0) begin miscompares++; $display("FAIL rmid_tie_who: got %0d expected 0", r_who); end
    vectors++; if (r_done_cyc !== 3) begin miscompares++; $display("FAIL rmid_cycle: got %0d expected 3", r_done_cyc); end
    model_last = 0;
    serve(0, 32'h1111_2222, 1'b0, 1'b0);
    vectors++; if (r_who !== 1) begin miscompares++; $display("FAIL rmid_next_who: got %0d expected 1", r_who); end
    vectors++; if (r_rdata !== 32'h1111_2222) begin miscompares++; $display("FAIL rmid_next_prdata: got %h expected 11112222", r_rdata); end
    model_last = 1;
  endtask

  task automatic test_back_to_back();
    m0_psel = 1'b1; m0_paddr = 32'h0000_1010; m0_pwrite = 1'b0;
    m1_psel = 1'b1; m1_paddr = 32'h0000_2020; m1_pwrite = 1'b0;
    serve(0, 32'h0000_00B0, 1'b0, 1'b1);
    vectors++; if (r_who !== 0) begin miscompares++; $display("FAIL b2b_first_who: got %0d expected 0", r_who); end
    vectors++; if (s_psel !== 1'b0) begin miscompares++; $display("FAIL b2b_gap: got %b expected 0", s_psel); end
    model_last = 0;
    serve(0, 32'h0000_00B1, 1'b0, 1'b0);
    vectors++; if (r_who !== 1) begin miscompares++; $display("FAIL b2b_second_who: got %0d expected 1", r_who); end
    vectors++; if (r_psel_cyc !== 1) begin miscompares++; $display("FAIL b2b_second_psel: got %0d expected 1", r_psel_cyc); end
    model_last = 1;
    serve(0, 32'h0000_00B2, 1'b0, 1'b0);
    vectors++; if (r_who !== 0) begin miscompares++; $display("FAIL b2b_third_who: got %0d expected 0", r_who); end
    model_last = 0;
  endtask

  task automatic test_random();
    int          waits, exp_who, exp_done;
    logic [31:0] rnd, rd, exp_addr, exp_wdata, exp_rdata;
    logic        er, exp_wr, exp_err;
    bit          exp_tmo;
    for (int it = 0; it < 40; it++) begin
      rnd = $urandom;
      if (!m0_psel && rnd[0]) begin m0_psel = 1'b1; m0_paddr = $urandom; m0_pwdata = $urandom; m0_pwrite = rnd[2]; end
      if (!m1_psel && rnd[1]) begin m1_psel = 1'b1; m1_paddr = $urandom; m1_pwdata = $urandom; m1_pwrite = rnd[3]; end
      if (!m0_psel && !m1_psel) begin m1_psel = 1'b1; m1_paddr = $urandom; m1_pwdata = $urandom; m1_pwrite = rnd[5]; end
      waits = $urandom_range(20, 0);
      rd = $urandom; er = rnd[4];
      if (m0_psel && m1_psel) exp_who = (model_last == 0) ? 1 : 0;
      else exp_who = m1_psel ? 1 : 0;
      exp_addr  = (exp_who == 1) ? m1_paddr  : m0_paddr;
      exp_wdata = (exp_who == 1) ? m1_pwdata : m0_pwdata;
      exp_wr    = (exp_who == 1) ? m1_pwrite : m0_pwrite;
      exp_tmo   = (waits >= TIMEOUT);
      exp_done  = exp_tmo ? TIMEOUT + 1 : waits + 2;
      exp_rdata = exp_tmo ? 32'h0 : rd;
      exp_err   = exp_tmo ? 1'b1 : er;
      serve(waits, rd, er, 1'b0);
      vectors++; if (r_who !== exp_who) begin miscompares++; $display("FAIL rand_who it=%0d: got %0d expected %0d", it, r_who, exp_who); end
      vectors++; if (r_done_cyc !== exp_done) begin miscompares++; $display("FAIL rand_cycle it=%0d: got %0d expected %0d", it, r_done_cyc, exp_done); end
      vectors++; if ({r_paddr, r_pwdata, r_pwrite} !== {exp_addr, exp_wdata, exp_wr}) begin
        miscompares++; $display("FAIL rand_req it=%0d: got %h/%h/%b expected %h/%h/%b", it, r_paddr, r_pwdata, r_pwrite, exp_addr, exp_wdata, exp_wr);
      end
      vectors++; if ({r_rdata, r_err} !== {exp_rdata, exp_err}) begin
        miscompares++; $display("FAIL rand_resp it=%0d: got %h/%b expected %h/%b", it, r_rdata, r_err, exp_rdata, exp_err);
      end
      vectors++; if (timeout_evt !== exp_tmo) begin miscompares++; $display("FAIL rand_evt it=%0d: got %b expected %b", it, timeout_evt, exp_tmo); end
      vectors++; if ({r_other_bad, r_unstable, r_evt_during} !== {32'd0, 32'd0, 32'd0}) begin
        miscompares++; $display("FAIL rand_side it=%0d: got other=%0d unstable=%0d evt=%0d expected 0/0/0", it, r_other_bad, r_unstable, r_evt_during);
      end
      model_last = exp_who;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
